button_frontend: RTL
====================

// Module: button_frontend
// PURPOSE
//  Conditions the five raw board push-buttons (L/R/U/D/C) before they reach core's
//   *_btn / *_btn_dn inputs.
//  Per button: 2-FF synchroniser, counter-based debounce and edge pulses.
//  Also emits an auto-repeat pulse train while a button is held.
//  Sits between the top-level pins and core, on the pixel clock.
// PARAMETERS
//  NBTN         5        number of buttons; index 0..4 = L,R,U,D,C
//  DEBOUNCE_CYC 400000   consecutive stable cycles needed to accept a new level (10 ms @ 40 MHz)
//  REPEAT_DLY   20000000 held cycles before the first repeat pulse (0.5 s)
//  REPEAT_PER   4000000  cycles between subsequent repeat pulses (0.1 s)
// PORTS
//  clk      in   1     pixel clock; single clock domain
//  rst      in   1     synchronous, active-high reset
//  btn_raw  in   NBTN  asynchronous raw button pins, 1 = pressed
//  btn      out  NBTN  debounced level; feeds core *_btn
//  btn_dn   out  NBTN  1-cycle pulse on accepted press (0->1); feeds core *_btn_dn
//  btn_up   out  NBTN  1-cycle pulse on accepted release (1->0)
//  btn_rep  out  NBTN  1-cycle repeat pulse while held
// BEHAVIOUR
//  Reset
//   - All outputs 0; synchroniser flops 0; FSM in REL; counters 0.
//   - Reset asserted mid-press forces this state too.
//   - A button still held after reset is re-detected as a fresh press, including a btn_dn pulse.
//  Synchroniser
//   - s1 <= btn_raw; s2 <= s1. Only s2 is used downstream.
//  Per-channel FSM (registered; all outputs registered)
//   - REL:  btn=0. s2=1 -> P_WAIT, cnt<=1.
//   - P_WAIT: s2=0 -> REL, cnt<=0 (bounce discards).
//       s2=1 and cnt==DEBOUNCE_CYC-1 -> HELD; btn<=1, btn_dn<=1 for one cycle, hold<=0.
//       Otherwise cnt++.
//   - HELD: btn=1; hold++ every cycle. s2=0 -> R_WAIT, cnt<=1.
//   - R_WAIT: s2=1 -> HELD, cnt<=0; hold keeps counting, btn stays 1.
//       s2=0 and cnt==DEBOUNCE_CYC-1 -> REL; btn<=0, btn_up<=1 for one cycle.
//       Otherwise cnt++.
//  Latency
//   - From the first clock edge sampling a new stable raw level to the btn/btn_dn/btn_up
//     change: exactly DEBOUNCE_CYC+2 edges.
//  Repeat
//   - In HELD or R_WAIT: btn_rep pulses when hold==REPEAT_DLY.
//   - It then pulses every REPEAT_PER cycles thereafter: hold reloads to REPEAT_DLY-REPEAT_PER+1.
//   - btn_rep never coincides with btn_dn; it is 0 outside HELD/R_WAIT.
//  Widths and arithmetic
//   - cnt: $clog2(DEBOUNCE_CYC) bits; hold: $clog2(REPEAT_DLY+1) bits; both unsigned.
//   - Neither counter may wrap. cnt is bounded by the FSM; hold is bounded by the reload.
//  Boundaries
//   - Channels are fully independent; simultaneous presses each produce their own btn_dn in
//     the same cycle.
//   - btn_dn and btn_up are never high together on one channel.
//   - A pulse train faster than DEBOUNCE_CYC never changes btn.
//   - Parameter legality (elaboration $error otherwise): DEBOUNCE_CYC>=2,
//     REPEAT_PER>=1, REPEAT_DLY>=REPEAT_PER.
// STRUCTURE
//  - Package button_pkg holds:
//     - typedef enum logic [1:0] {REL, P_WAIT, HELD, R_WAIT} btn_state_t
//     - localparam indices BTN_L=0, BTN_R=1, BTN_U=2, BTN_D=3, BTN_C=4
//  - Sub-module button_debounce_ch: one channel (sync, FSM, cnt, hold, 4 outputs).
//  - Top instantiates NBTN of them with a generate loop.
// TESTING (bench with DEBOUNCE_CYC=4, REPEAT_DLY=10, REPEAT_PER=3)
//  1. rst 1 cycle; raw=0 -> all outputs 0. Raw L=1 held -> btn[0] rises and btn_dn[0]=1
//     exactly 6 edges after the first sampling edge; btn_dn high 1 cycle only.
//  2. Raw U toggles 1,1,0,1,1,0 (period below 4) -> btn[2], btn_dn[2] stay 0 throughout.
//  3. L held stable 30 cycles -> btn_rep[0] first at hold==10, then every 3 cycles
//     (10, 13, 16, ...); release -> btn_up[0] after 6 edges; btn_rep stops.
//  4. While C is HELD, a 2-cycle low glitch -> btn[4] stays 1, no btn_up; repeat timing unchanged.
//  5. L and R pressed on the same edge -> btn_dn[0] and btn_dn[1] pulse in the same cycle.
//  6. rst asserted while D is HELD, raw still 1 -> outputs 0 next cycle; after rst drops,
//     btn_dn[3] fires again 6 edges later.

Source files
------------

// File: rtl/button_frontend_pkg.sv
// Shared types and constants for the push-button front end.
//   btn_state_t : per-channel debounce FSM state
//   BTN_*       : bit index of each board button in the NBTN-wide vectors
package button_pkg;

  typedef enum logic [1:0] {
    REL    = 2'd0,
    P_WAIT = 2'd1,
    HELD   = 2'd2,
    R_WAIT = 2'd3
  } btn_state_t;

  localparam int unsigned BTN_L = 0;
  localparam int unsigned BTN_R = 1;
  localparam int unsigned BTN_U = 2;
  localparam int unsigned BTN_D = 3;
  localparam int unsigned BTN_C = 4;

endpackage

// File: rtl/button_frontend_if.sv
// Button bundle between board pins, the front end and core.
//   btn_raw : raw asynchronous pins, 1 = pressed
//   btn     : debounced level
//   btn_dn  : 1-cycle pulse on accepted press
//   btn_up  : 1-cycle pulse on accepted release
//   btn_rep : 1-cycle auto-repeat pulse while held
// master = board/core side (drives pins), slave = button_frontend.
interface button_frontend_if #(
  parameter int unsigned NBTN = 5
) ();
  logic [NBTN-1:0] btn_raw;
  logic [NBTN-1:0] btn;
  logic [NBTN-1:0] btn_dn;
  logic [NBTN-1:0] btn_up;
  logic [NBTN-1:0] btn_rep;

  modport master (output btn_raw, input btn, btn_dn, btn_up, btn_rep);
  modport slave  (input btn_raw, output btn, btn_dn, btn_up, btn_rep);
endinterface

// File: rtl/button_frontend_debounce_ch.sv
// One button channel: 2-FF synchroniser, counter debounce FSM, edge pulses
// and auto-repeat.
//   clk, rst : clock, synchronous active-high reset
//   raw      : asynchronous raw pin
//   btn      : debounced level
//   btn_dn   : press pulse
//   btn_up   : release pulse
//   btn_rep  : repeat pulse while held
module button_debounce_ch
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 400000,
  parameter int unsigned REPEAT_DLY   = 20000000,
  parameter int unsigned REPEAT_PER   = 4000000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic btn,
  output logic btn_dn,
  output logic btn_up,
  output logic btn_rep
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYC);
  localparam int unsigned HW = $clog2(REPEAT_DLY + 1);

  localparam logic [CW-1:0] CNT_ONE     = CW'(1);
  localparam logic [CW-1:0] CNT_LAST    = CW'(DEBOUNCE_CYC - 1);
  localparam logic [HW-1:0] HOLD_ONE    = HW'(1);
  localparam logic [HW-1:0] HOLD_DLY    = HW'(REPEAT_DLY);
  localparam logic [HW-1:0] HOLD_RELOAD = HW'(REPEAT_DLY - REPEAT_PER + 1);

  logic          s1_q, s1_d, s2_q, s2_d;
  btn_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [HW-1:0] hold_q, hold_d, hold_next;
  logic          btn_q, btn_d, btn_dn_q, btn_dn_d;
  logic          btn_up_q, btn_up_d, btn_rep_q, btn_rep_d;

  assign s1_d = raw;
  assign s2_d = s1_q;

  // Reloading just past the first repeat point gives a REPEAT_PER period
  // and keeps hold from ever wrapping.
  assign hold_next = (hold_q == HOLD_DLY) ? HOLD_RELOAD : hold_q + HOLD_ONE;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      state_q   <= REL;
      cnt_q     <= '0;
      hold_q    <= '0;
      btn_q     <= 1'b0;
      btn_dn_q  <= 1'b0;
      btn_up_q  <= 1'b0;
      btn_rep_q <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      btn_q     <= btn_d;
      btn_dn_q  <= btn_dn_d;
      btn_up_q  <= btn_up_d;
      btn_rep_q <= btn_rep_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    hold_d  = '0;
    case (state_q)
      REL: begin
        if (s2_q) begin
          state_d = P_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      P_WAIT: begin
        if (!s2_q) begin
          state_d = REL;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HELD: begin
        hold_d = hold_next;
        if (!s2_q) begin
          state_d = R_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      R_WAIT: begin
        if (s2_q) begin
          state_d = HELD;
          hold_d  = hold_next;
        end else if (cnt_q == CNT_LAST) begin
          state_d = REL;
        end else begin
          cnt_d  = cnt_q + CNT_ONE;
          hold_d = hold_next;
        end
      end
      default: state_d = REL;
    endcase
  end

  always_comb begin
    btn_d     = (state_d == HELD) || (state_d == R_WAIT);
    btn_dn_d  = (state_q == P_WAIT) && (state_d == HELD);
    btn_up_d  = (state_q == R_WAIT) && (state_d == REL);
    btn_rep_d = btn_d && (hold_d == HOLD_DLY);
  end

  assign btn     = btn_q;
  assign btn_dn  = btn_dn_q;
  assign btn_up  = btn_up_q;
  assign btn_rep = btn_rep_q;

endmodule

// File: rtl/button_frontend.sv
// Conditions the raw board push-buttons (L/R/U/D/C) for core: one
// independent debounce/repeat channel per button, all on the pixel clock.
//   clk : pixel clock
//   rst : synchronous active-high reset
//   bus : button bundle (slave side): btn_raw in; btn/btn_dn/btn_up/btn_rep out
module button_frontend
  import button_pkg::*;
#(
  parameter int unsigned NBTN         = 5,
  parameter int unsigned DEBOUNCE_CYC = 400000,
  parameter int unsigned REPEAT_DLY   = 20000000,
  parameter int unsigned REPEAT_PER   = 4000000
) (
  input  logic                     clk,
  input  logic                     rst,
  button_frontend_if.slave         bus
);

  if (DEBOUNCE_CYC < 2) begin : g_chk_deb
    $error("DEBOUNCE_CYC must be >= 2");
  end
  if (REPEAT_PER < 1) begin : g_chk_per
    $error("REPEAT_PER must be >= 1");
  end
  if (REPEAT_DLY < REPEAT_PER) begin : g_chk_dly
    $error("REPEAT_DLY must be >= REPEAT_PER");
  end

  logic [NBTN-1:0] btn_v, btn_dn_v, btn_up_v, btn_rep_v;

  for (genvar i = 0; i < NBTN; i++) begin : g_ch
    button_debounce_ch #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .REPEAT_DLY   (REPEAT_DLY),
      .REPEAT_PER   (REPEAT_PER)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .raw     (bus.btn_raw[i]),
      .btn     (btn_v[i]),
      .btn_dn  (btn_dn_v[i]),
      .btn_up  (btn_up_v[i]),
      .btn_rep (btn_rep_v[i])
    );
  end

  assign bus.btn     = btn_v;
  assign bus.btn_dn  = btn_dn_v;
  assign bus.btn_up  = btn_up_v;
  assign bus.btn_rep = btn_rep_v;

endmodule
